// File: rtl/npn4_pkg.sv
// Shared types and constants for the 4-input NPN canonicalizer.
// PERM_TABLE entry k holds (p0..p3) in element [i] = p_i, lexicographic in (p0,p1,p2,p3).
package npn4_pkg;

   typedef logic [15:0]     tt_t;
   typedef logic [3:0][1:0] perm_t;

   localparam int N_PERM        = 24;
   localparam int N_PHASE       = 16;
   localparam int SEARCH_CYCLES = N_PERM * N_PHASE;

   // Literals are written p3_p2_p1_p0.
   localparam perm_t PERM_TABLE [N_PERM] = '{
      8'b11_10_01_00, 8'b10_11_01_00, 8'b11_01_10_00, 8'b01_11_10_00,
      8'b10_01_11_00, 8'b01_10_11_00, 8'b11_10_00_01, 8'b10_11_00_01,
      8'b11_00_10_01, 8'b00_11_10_01, 8'b10_00_11_01, 8'b00_10_11_01,
      8'b11_01_00_10, 8'b01_11_00_10, 8'b11_00_01_10, 8'b00_11_01_10,
      8'b01_00_11_10, 8'b00_01_11_10, 8'b10_01_00_11, 8'b01_10_00_11,
      8'b10_00_01_11, 8'b00_10_01_11, 8'b01_00_10_11, 8'b00_01_10_11
   };

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

endpackage

// File: rtl/npn4_transform.sv
// Combinational NP transform: t'[m] = t[P(m) ^ phase], bit i of P(m) = bit p_i of m.
// The output-negated variant is the bitwise complement of this result.
module npn4_transform
   import npn4_pkg::*;
(
   input  tt_t        tt_in,
   input  logic [4:0] perm_idx,
   input  logic [3:0] phase,
   output tt_t        tt_out
);

   perm_t      p;
   logic [3:0] mv;
   logic [3:0] src;

   always_comb begin
      p      = PERM_TABLE[perm_idx];
      tt_out = '0;
      mv     = '0;
      src    = '0;
      for (int m = 0; m < 16; m++) begin
         mv = 4'(m);
         for (int i = 0; i < 4; i++) begin
            src[i] = mv[p[i]];
         end
         src       = src ^ phase;
         tt_out[m] = tt_in[src];
      end
   end

endmodule

// File: rtl/npn4_canonicalizer.sv
// Serial NPN canonicalizer: one (perm,phase) pair per cycle, both output phases at once.
// Optional macro NPN4_CANON_EARLY_EXIT_EN ends the search as soon as the best value is 0x0000.
module npn4_canonicalizer
   import npn4_pkg::*;
#(
   parameter int OUT_NEG_SEARCH = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_tt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_tt,
   output logic [4:0]  out_perm,
   output logic [3:0]  out_phase,
   output logic        out_neg
);

   state_t     state_q, state_d;
   tt_t        tt_q, tt_d;
   tt_t        best_q, best_d;
   logic [4:0] best_perm_q, best_perm_d;
   logic [3:0] best_phase_q, best_phase_d;
   logic       best_neg_q, best_neg_d;
   logic [4:0] perm_q, perm_d;
   logic [3:0] phase_q, phase_d;
   logic       out_valid_q, out_valid_d;
   tt_t        out_tt_q, out_tt_d;
   logic [4:0] out_perm_q, out_perm_d;
   logic [3:0] out_phase_q, out_phase_d;
   logic       out_neg_q, out_neg_d;

   tt_t  cand;
   tt_t  cand_n;
   logic early_done;

   npn4_transform u_xform (
      .tt_in    (tt_q),
      .perm_idx (perm_q),
      .phase    (phase_q),
      .tt_out   (cand)
   );

   assign cand_n = ~cand;

`ifdef NPN4_CANON_EARLY_EXIT_EN
   assign early_done = (best_q == 16'h0000);
`else
   assign early_done = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      tt_d         = tt_q;
      best_d       = best_q;
      best_perm_d  = best_perm_q;
      best_phase_d = best_phase_q;
      best_neg_d   = best_neg_q;
      perm_d       = perm_q;
      phase_d      = phase_q;
      out_valid_d  = out_valid_q;
      out_tt_d     = out_tt_q;
      out_perm_d   = out_perm_q;
      out_phase_d  = out_phase_q;
      out_neg_d    = out_neg_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               tt_d         = in_tt;
               best_d       = in_tt;
               best_perm_d  = '0;
               best_phase_d = '0;
               best_neg_d   = 1'b0;
               perm_d       = '0;
               phase_d      = '0;
               state_d      = SEARCH;
            end
         end
         SEARCH: begin
            if (early_done) begin
               state_d = DONE;
            end else begin
               // Strict less-than with o=0 first keeps the earliest transform on ties.
               if (cand < best_q) begin
                  best_d       = cand;
                  best_perm_d  = perm_q;
                  best_phase_d = phase_q;
                  best_neg_d   = 1'b0;
               end
               if ((OUT_NEG_SEARCH != 0) && (cand_n < best_d)) begin
                  best_d       = cand_n;
                  best_perm_d  = perm_q;
                  best_phase_d = phase_q;
                  best_neg_d   = 1'b1;
               end
               phase_d = phase_q + 4'd1;
               if (phase_q == 4'd15) begin
                  perm_d = perm_q + 5'd1;
                  if (perm_q == 5'd23) begin
                     state_d = DONE;
                  end
               end
            end
         end
         DONE: begin
            // First DONE cycle registers the result; handshake is honoured only once valid.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_tt_d    = best_q;
               out_perm_d  = best_perm_q;
               out_phase_d = best_phase_q;
               out_neg_d   = best_neg_q;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         tt_q         <= '0;
         best_q       <= '0;
         best_perm_q  <= '0;
         best_phase_q <= '0;
         best_neg_q   <= 1'b0;
         perm_q       <= '0;
         phase_q      <= '0;
         out_valid_q  <= 1'b0;
         out_tt_q     <= '0;
         out_perm_q   <= '0;
         out_phase_q  <= '0;
         out_neg_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tt_q         <= tt_d;
         best_q       <= best_d;
         best_perm_q  <= best_perm_d;
         best_phase_q <= best_phase_d;
         best_neg_q   <= best_neg_d;
         perm_q       <= perm_d;
         phase_q      <= phase_d;
         out_valid_q  <= out_valid_d;
         out_tt_q     <= out_tt_d;
         out_perm_q   <= out_perm_d;
         out_phase_q  <= out_phase_d;
         out_neg_q    <= out_neg_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign out_tt    = out_tt_q;
   assign out_perm  = out_perm_q;
   assign out_phase = out_phase_q;
   assign out_neg   = out_neg_q;

endmodule

// File: tb/tb_npn4_canonicalizer.sv
// Bench for npn4_canonicalizer: directed cases plus random truth tables against a
// brute-force NPN reference; NPN4_CANON_EARLY_EXIT_EN changes only expected latency.
module tb_npn4_canonicalizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_tt;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_tt;
   logic [4:0]  out_perm;
   logic [3:0]  out_phase;
   logic        out_neg;

   always #5 clk = ~clk;

   npn4_canonicalizer #(.OUT_NEG_SEARCH(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_tt     (in_tt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tt    (out_tt),
      .out_perm  (out_perm),
      .out_phase (out_phase),
      .out_neg   (out_neg)
   );

`ifdef NPN4_CANON_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   int perm_p [24][4];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // All 24 permutations in lexicographic order of (p0,p1,p2,p3).
   task automatic build_perms();
      int k = 0;
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int c = 0; c < 4; c++)
               for (int d = 0; d < 4; d++)
                  if (a != b && a != c && a != d && b != c && b != d && c != d) begin
                     perm_p[k][0] = a; perm_p[k][1] = b;
                     perm_p[k][2] = c; perm_p[k][3] = d;
                     k++;
                  end
   endtask

   function automatic logic [15:0] apply(input logic [15:0] t, input int k, input int n, input int o);
      logic [15:0] r = '0;
      for (int m = 0; m < 16; m++) begin
         int src = 0;
         for (int i = 0; i < 4; i++)
            if (((m >> perm_p[k][i]) & 1) == 1) src += (1 << i);
         src = src ^ n;
         r[m] = t[src] ^ (o == 1);
      end
      return r;
   endfunction

   task automatic model(input logic [15:0] t, output logic [15:0] b, output int bp,
                        output int bph, output int bn, output int lat);
      b = t; bp = 0; bph = 0; bn = 0; lat = 385;
      for (int idx = 0; idx < 384; idx++) begin
         if (EE && b == 16'h0000) begin
            lat = idx + 2;
            break;
         end
         for (int o = 0; o < 2; o++) begin
            logic [15:0] c = apply(t, idx / 16, idx % 16, o);
            if (c < b) begin
               b = c; bp = idx / 16; bph = idx % 16; bn = o;
            end
         end
      end
   endtask

   task automatic start_and_wait(input logic [15:0] t, output int cyc);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 1000) begin
         @(negedge clk);
         w++;
      end
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_tt    = t;
      in_valid = 1'b1;
      @(posedge clk);
      cyc = 0;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && cyc < 1000) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic release_result(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_expect(input string tag, input logic [15:0] t, input logic [15:0] e_tt,
                             input int e_perm, input int e_phase, input int e_neg, input int e_lat);
      int cyc;
      start_and_wait(t, cyc);
      check({tag, "_latency"}, 32'(cyc), 32'(e_lat));
      check({tag, "_tt"}, 32'(out_tt), 32'(e_tt));
      check({tag, "_perm"}, 32'(out_perm), 32'(e_perm));
      check({tag, "_phase"}, 32'(out_phase), 32'(e_phase));
      check({tag, "_neg"}, 32'(out_neg), 32'(e_neg));
   endtask

   task automatic run_model(input string tag, input logic [15:0] t);
      logic [15:0] b;
      int bp, bph, bn, lat;
      model(t, b, bp, bph, bn, lat);
      run_expect(tag, t, b, bp, bph, bn, lat);
      release_result(tag);
   endtask

   initial begin
      logic [15:0] b;
      int bp, bph, bn, lat, cyc;
      build_perms();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_tt = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_tt", 32'(out_tt), 32'd0);
      check("rst_out_perm", 32'(out_perm), 32'd0);

      // AND4 with a stray out_ready while idle, which must be ignored.
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_out_ready_ignored", 32'(out_valid), 32'd0);
      model(16'h8000, b, bp, bph, bn, lat);
      run_expect("and4", 16'h8000, 16'h0001, 0, 15, 0, lat);
      release_result("and4");

      model(16'hFFFF, b, bp, bph, bn, lat);
      run_expect("const1", 16'hFFFF, 16'h0000, 0, 0, 1, lat);
      release_result("const1");

      model(16'h6996, b, bp, bph, bn, lat);
      run_expect("xor4", 16'h6996, 16'h6996, 0, 0, 0, lat);
      release_result("xor4");

      run_expect("const0", 16'h0000, 16'h0000, 0, 0, 0, EE ? 2 : 385);
      release_result("const0");

      // Result held while out_ready stays low; new offers are ignored.
      model(16'h8000, b, bp, bph, bn, lat);
      run_expect("hold", 16'h8000, 16'h0001, 0, 15, 0, lat);
      for (int i = 0; i < 20; i++) begin
         in_tt    = 16'h1234;
         in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_tt", 32'(out_tt), 32'h0001);
         check("hold_phase", 32'(out_phase), 32'hF);
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      release_result("hold");

      // Reset 100 cycles into a search discards it.
      start_and_wait(16'hFFFF, cyc);
      release_result("pre_reset");
      @(negedge clk);
      in_tt = 16'hBEEF; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_tt", 32'(out_tt), 32'd0);
      check("midrst_out_neg", 32'(out_neg), 32'd0);
      check("midrst_out_phase", 32'(out_phase), 32'd0);
      model(16'h0001, b, bp, bph, bn, lat);
      run_expect("post_rst", 16'h0001, 16'h0001, 0, 0, 0, lat);
      release_result("post_rst");

      for (int r = 0; r < 8; r++) begin
         logic [15:0] t;
         t = 16'($urandom);
         if (r == 0) t = t & 16'h0303;
         run_model($sformatf("rand%0d", r), t);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/npn4_canonicalizer.md
Name: npn4_canonicalizer

Overview:
- Upstream stage of the 4-input NPN exact-synthesis flow.
- Takes a 16-bit truth table and serially searches all 768 NPN transforms (24 permutations x 16 input phases x 2 output phases).
- Returns the canonical representative and the transform that produced it. Downstream per-class exact AIG circuits and the class lookup key on the canonical value.

Parameters:
- OUT_NEG_SEARCH, 1, 1 = NPN canonical form (output negation searched); 0 = NP form only (out_neg output always 0).
- SEARCH_CYCLES, 384, fixed at N_PERM*N_PHASE; localparam, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  truth table offered.
- in_ready  out  1  block idle, can accept.
- in_tt  in  16  truth table; bit m = f(x3..x0 = m).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_tt  out  16  canonical truth table.
- out_perm  out  5  permutation index 0..23, lexicographic order of (p0,p1,p2,p3).
- out_phase  out  4  input negation mask.
- out_neg  out  1  output negated.

Behaviour:
- Transform definition: t'[m] = o ^ t[P(m) ^ N]. Bit i of P(m) = bit p_i of m. N = phase mask, o = output negation.
- Canonical value: the minimum unsigned 16-bit t' over the searched set.
- Ties resolve to the first transform encountered. Iteration order: perm outer 0..23, phase inner 0..15, o=0 before o=1.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_tt; best=in_tt, best_perm=0, best_phase=0, best_neg=0; perm=0, phase=0; go to SEARCH.
- SEARCH:
  - in_ready=0.
  - Each cycle evaluates the current (perm,phase) for o=0 and, if OUT_NEG_SEARCH, also o=1.
  - Replaces best only on strict less-than. o=0 is compared first.
  - Then phase increments; at phase=15 it wraps to 0 and perm increments.
  - The cycle that evaluates perm=23, phase=15 transitions to DONE.
  - Exactly 384 SEARCH cycles. out_valid rises 385 cycles after the accepting edge.
- DONE:
  - out_valid=1. Outputs are registered and stable.
  - On out_ready, go to IDLE; in_ready is 1 the following cycle.
  - out_ready held low: remain in DONE indefinitely, outputs unchanged.
- out_ready asserted while not in DONE: ignored.
- in_valid outside IDLE: ignored, no latching.
- Reset (any state, including mid-SEARCH): state=IDLE, out_valid=0, in_ready=1 from the first cycle after reset. out_tt, out_perm, out_phase, out_neg = 0. Any search in progress is discarded.
- Widths: perm counter 5 bits, phase 4 bits. No other arithmetic.

Optional Feature:
- Macro: NPN4_CANON_EARLY_EXIT_EN.
- Defined:
  - If best == 0x0000 at the start of any SEARCH cycle, go directly to DONE without evaluating further.
  - Reported transform is the first one reaching 0x0000.
  - Accepting in_tt=0x0000 gives out_valid 2 cycles after acceptance.
- Undefined: fixed 384-cycle search regardless of value.

Decomposition:
- Package npn4_pkg:
  - typedef tt_t = logic[15:0].
  - N_PERM=24, N_PHASE=16, SEARCH_CYCLES=384.
  - Constant PERM_TABLE[24] of four 2-bit entries (p0..p3), lexicographic.
  - State enum {IDLE, SEARCH, DONE}.
- Sub-module npn4_transform: purely combinational (tt, perm_idx, phase) -> transformed tt for o=0. The o=1 result is its bitwise complement. The canonicalizer is FSM, counters and best-register only.

Test Plan:
- in_tt=0x8000 (AND4) -> out_tt=0x0001, out_perm=0, out_phase=0xF, out_neg=0; out_valid exactly 385 cycles after accept.
- in_tt=0xFFFF -> out_tt=0x0000, perm=0, phase=0, neg=1. With OUT_NEG_SEARCH=0 -> out_tt=0xFFFF, neg=0.
- in_tt=0x6996 (XOR4) -> out_tt=0x6996, perm=0, phase=0, neg=0 (identity wins tie).
- Result 0x8000: hold out_ready low 20 cycles -> out_valid stays 1, outputs stable, in_ready=0, new in_valid ignored. Raise out_ready -> in_ready=1 next cycle.
- Assert rst 100 cycles into a search -> next cycle out_valid=0, in_ready=1, outputs 0. New in_tt=0x0001 -> out_tt=0x0001, perm=0, phase=0, neg=0.
- With NPN4_CANON_EARLY_EXIT_EN: in_tt=0x0000 -> out_valid 2 cycles after accept, out_tt=0x0000, perm=0, phase=0, neg=0. Same input without the macro -> 385 cycles, same result.
